// File: rtl/sequenciador_entrada_if.sv
// Entry-sequencer request channel: operands and op code offered under valid/ready,
// completion returned as a one-cycle done pulse with result and error flag.
interface sequenciador_entrada_if;
    logic       op_valid;
    logic       op_ready;
    logic       op_done;
    logic       op_erro;
    logic [7:0] resultado_in;
    logic [7:0] operando_a;
    logic [7:0] operando_b;
    logic [2:0] codigo_op;

    modport master (
        output op_valid, operando_a, operando_b, codigo_op,
        input  op_ready, op_done, op_erro, resultado_in
    );

    modport slave (
        input  op_valid, operando_a, operando_b, codigo_op,
        output op_ready, op_done, op_erro, resultado_in
    );
endinterface

// File: rtl/sequenciador_entrada.sv
// Debounced key entry sequencer: captures A, B and op code on successive presses,
// issues the request over valid/ready and waits (with timeout) for completion.
module sequenciador_entrada #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_key_n,
    input  logic [7:0]                    i_sw_valor,
    sequenciador_entrada_if.master        op_if,
    output logic [7:0]                    o_resultado,
    output logic [1:0]                    o_estado,
    output logic                          o_ocupado,
    output logic                          o_erro
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StEsperaA,
        StEsperaB,
        StEsperaOp,
        StEmite,
        StAguarda
    } state_e;

    logic [1:0]     r_sync;
    logic           r_db;
    logic           r_db_prev;
    logic [DbW-1:0] r_db_cnt;
    logic           w_press;

    state_e         r_state, w_state_next;
    logic [7:0]     r_op_a, w_op_a_next;
    logic [7:0]     r_op_b, w_op_b_next;
    logic [2:0]     r_code, w_code_next;
    logic [7:0]     r_resultado, w_resultado_next;
    logic           r_erro, w_erro_next;
    logic [ToW-1:0] r_to_cnt, w_to_cnt_next;

    // Key synchronizer and debouncer; the raw key is asynchronous to i_clk.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync    <= 2'b11;
            r_db      <= 1'b1;
            r_db_prev <= 1'b1;
            r_db_cnt  <= '0;
        end else begin
            r_sync    <= {r_sync[0], i_key_n};
            r_db_prev <= r_db;
            if (r_sync[1] == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DbMax) begin
                r_db     <= r_sync[1];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_press = r_db_prev & ~r_db;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StEsperaA;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_code      <= '0;
            r_resultado <= '0;
            r_erro      <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_op_a      <= w_op_a_next;
            r_op_b      <= w_op_b_next;
            r_code      <= w_code_next;
            r_resultado <= w_resultado_next;
            r_erro      <= w_erro_next;
            r_to_cnt    <= w_to_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_op_a_next      = r_op_a;
        w_op_b_next      = r_op_b;
        w_code_next      = r_code;
        w_resultado_next = r_resultado;
        w_erro_next      = r_erro;
        w_to_cnt_next    = r_to_cnt;
        case (r_state)
            StEsperaA: begin
                if (w_press) begin
                    w_op_a_next  = i_sw_valor;
                    w_erro_next  = 1'b0;
                    w_state_next = StEsperaB;
                end
            end
            StEsperaB: begin
                if (w_press) begin
                    w_op_b_next  = i_sw_valor;
                    w_state_next = StEsperaOp;
                end
            end
            StEsperaOp: begin
                // Out-of-range codes flag an error but keep waiting for a valid one.
                if (w_press) begin
                    if (i_sw_valor[7:3] == 5'd0) begin
                        w_code_next  = i_sw_valor[2:0];
                        w_state_next = StEmite;
                    end else begin
                        w_erro_next = 1'b1;
                    end
                end
            end
            StEmite: begin
                if (op_if.op_ready) begin
                    w_to_cnt_next = '0;
                    w_state_next  = StAguarda;
                end
            end
            StAguarda: begin
                // A done pulse on the last count still wins over the timeout.
                if (op_if.op_done) begin
                    w_resultado_next = op_if.resultado_in;
                    w_erro_next      = op_if.op_erro;
                    w_state_next     = StEsperaA;
                end else if (r_to_cnt == ToMax) begin
                    w_erro_next  = 1'b1;
                    w_state_next = StEsperaA;
                end else begin
                    w_to_cnt_next = r_to_cnt + 1'b1;
                end
            end
            default: w_state_next = StEsperaA;
        endcase
    end

    always_comb begin
        o_estado = 2'b11;
        case (r_state)
            StEsperaA:  o_estado = 2'b00;
            StEsperaB:  o_estado = 2'b01;
            StEsperaOp: o_estado = 2'b10;
            default:    o_estado = 2'b11;
        endcase
    end

    assign op_if.op_valid   = (r_state == StEmite);
    assign op_if.operando_a = r_op_a;
    assign op_if.operando_b = r_op_b;
    assign op_if.codigo_op  = r_code;
    assign o_resultado      = r_resultado;
    assign o_ocupado        = (r_state == StEmite) || (r_state == StAguarda);
    assign o_erro           = r_erro;

endmodule
